bitstring_deserializer: RTL and testbench
=========================================

// Module: bitstring_deserializer
// PURPOSE
//   Collects a serial bit stream into WIDTH-bit parallel words for the
//   Popcount stage directly downstream.
//   - Upstream: valid/ready serial handshake.
//   - Downstream: valid/ready word handshake. bitstring feeds Popcount.bitstring.
//   - Also counts delivered words for debug and bench scoreboarding.
// PARAMETERS
//   WIDTH   3  bits per word; matches Popcount input width; legal range >= 2
//   CNT_W   8  width of the delivered-word counter
// PORTS
//   clk          in   1        single clock; all state updates on rising edge
//   rst_n        in   1        asynchronous, active-low reset
//   sin_bit      in   1        serial data bit
//   sin_valid    in   1        sin_bit is valid this cycle
//   sin_ready    out  1        block accepts sin_bit this cycle
//   abort        in   1        synchronous flush of partial and pending word
//   bitstring    out  WIDTH    assembled word (first-received bit = MSB)
//   bs_valid     out  1        bitstring holds an undelivered word
//   bs_ready     in   1        downstream accepts bitstring this cycle
//   word_count   out  CNT_W    number of words delivered, modulo 2^CNT_W
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     state=COLLECT, bit_cnt=0, shift reg=0, bitstring=0, bs_valid=0,
//     word_count=0. sin_ready=1 once reset is released.
//   Events:
//     accept  = sin_valid && sin_ready
//     deliver = bs_valid && bs_ready
//   States:
//     COLLECT: sin_ready=1, bs_valid=0.
//       On accept: sr <= {sr[WIDTH-2:0], sin_bit}.
//       If bit_cnt==WIDTH-1:
//         bitstring <= {sr[WIDTH-2:0], sin_bit}; bs_valid<=1; bit_cnt<=0;
//         ->FULL. Else bit_cnt++.
//     FULL: bs_valid=1. sin_ready=bs_ready (combinational).
//       bitstring is stable until deliver.
//       deliver && !accept: bs_valid<=0, ->COLLECT.
//       deliver && accept: bit becomes bit 0 of the next word (bit_cnt<=1),
//         bs_valid<=0, ->COLLECT. No bubble.
//       !deliver: hold everything; no sin bit consumed.
//   word_count increments on every deliver; wraps 2^CNT_W-1 -> 0.
//   Latency: bs_valid rises on the same clock edge that accepts the WIDTH-th bit.
//   Throughput: one word per WIDTH cycles with continuous sin_valid and bs_ready.
//   bitstring keeps the last delivered word after delivery. It changes only
//     when a new word completes, abort, or reset.
//   abort (sync, highest priority):
//     sr<=0, bit_cnt<=0, bs_valid<=0, ->COLLECT.
//     A pending undelivered word is discarded and not counted.
//     bitstring and word_count are unchanged. Bits offered that cycle are
//     not consumed, but sin_ready still follows the state rule.
//   Async reset mid-word: all state cleared immediately; partial word lost.
//   Outputs have no X after reset. sin_ready has no combinational path
//     from sin_valid.
// TESTING
//   1 Reset: rst_n=0 mid-stream -> bs_valid=0, bitstring=000, word_count=0
//     immediately (async); sin_ready=1 after release.
//   2 Single word: bits 1,0,1 on consecutive cycles, bs_ready=1 ->
//     bs_valid high after 3rd edge for 1 cycle, bitstring=101, word_count=1.
//   3 Backpressure: word 110 completes with bs_ready=0 -> sin_ready=0,
//     bitstring stays 110. Raise bs_ready with sin_bit=1 -> deliver and
//     accept same edge; next word starts with bit_cnt=1.
//   4 Streaming: 9 bits 111000011, sin_valid=bs_ready=1 -> words 111,000,011,
//     bs_valid every 3rd cycle, no stalls, word_count=3.
//   5 Abort: 2 bits (1,1) then abort -> partial dropped. Next bits 0,0,1 ->
//     bitstring=001. Abort during FULL -> word dropped, word_count unchanged.
//   6 Wrap: deliver 256 words (CNT_W=8) -> word_count returns to 0.

Source files
------------

// File: rtl/bitstring_deserializer.sv
// Serial-to-parallel deserializer: packs WIDTH serial bits (first bit = MSB) into
// words for the downstream popcount stage, with valid/ready on both sides.
module bitstring_deserializer #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin_bit,
    input  logic             sin_valid,
    output logic             sin_ready,
    input  logic             abort,
    output logic [WIDTH-1:0] bitstring,
    output logic             bs_valid,
    input  logic             bs_ready,
    output logic [CNT_W-1:0] word_count
);

    localparam int unsigned BIT_CNT_W = $clog2(WIDTH);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(WIDTH - 1);

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_FULL    = 1'b1
    } state_t;

    state_t               r_state;
    logic [BIT_CNT_W-1:0] r_bit_cnt;
    logic [WIDTH-2:0]     r_sr;
    logic [WIDTH-1:0]     r_bitstring;
    logic                 r_bs_valid;
    logic [CNT_W-1:0]     r_word_count;

    logic                 w_accept;
    logic                 w_deliver;
    logic [WIDTH-1:0]     w_sr_next;

    // In FULL the slot frees up on the same edge it is delivered, so a new bit can enter.
    assign sin_ready  = (r_state == S_COLLECT) || bs_ready;
    assign w_accept   = sin_valid && sin_ready;
    assign w_deliver  = r_bs_valid && bs_ready;
    assign w_sr_next  = {r_sr, sin_bit};

    assign bitstring  = r_bitstring;
    assign bs_valid   = r_bs_valid;
    assign word_count = r_word_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_COLLECT;
            r_bit_cnt    <= '0;
            r_sr         <= '0;
            r_bitstring  <= '0;
            r_bs_valid   <= 1'b0;
            r_word_count <= '0;
        end else if (abort) begin
            // Flush partial and pending word; last delivered word and count survive.
            r_state    <= S_COLLECT;
            r_bit_cnt  <= '0;
            r_sr       <= '0;
            r_bs_valid <= 1'b0;
        end else begin
            case (r_state)
                S_COLLECT: begin
                    if (w_accept) begin
                        r_sr <= w_sr_next[WIDTH-2:0];
                        if (r_bit_cnt == LAST_BIT) begin
                            r_bitstring <= w_sr_next;
                            r_bs_valid  <= 1'b1;
                            r_bit_cnt   <= '0;
                            r_state     <= S_FULL;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
                        end
                    end
                end
                S_FULL: begin
                    if (w_deliver) begin
                        r_word_count <= r_word_count + CNT_W'(1);
                        r_bs_valid   <= 1'b0;
                        r_state      <= S_COLLECT;
                        if (w_accept) begin
                            r_sr      <= w_sr_next[WIDTH-2:0];
                            r_bit_cnt <= BIT_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitstring_deserializer.sv
// Directed self-checking bench for bitstring_deserializer (WIDTH=3, CNT_W=8).
module tb_bitstring_deserializer;

    logic       clk;
    logic       rst_n;
    logic       sin_bit;
    logic       sin_valid;
    logic       sin_ready;
    logic       abort;
    logic [2:0] bitstring;
    logic       bs_valid;
    logic       bs_ready;
    logic [7:0] word_count;

    int checks   = 0;
    int failures = 0;
    int exp_wc   = 0;

    bitstring_deserializer #(.WIDTH(3), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sin_bit    (sin_bit),
        .sin_valid  (sin_valid),
        .sin_ready  (sin_ready),
        .abort      (abort),
        .bitstring  (bitstring),
        .bs_valid   (bs_valid),
        .bs_ready   (bs_ready),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        sin_valid = 1'b1;
        sin_bit   = b;
        tick();
    endtask

    logic [8:0] stream;
    logic [2:0] exp_word;

    initial begin
        rst_n = 1'b1; sin_bit = 1'b0; sin_valid = 1'b0; abort = 1'b0; bs_ready = 1'b0;

        // Power-on reset
        #2 rst_n = 1'b0;
        #2;
        check_eq("rst_bs_valid", 32'(bs_valid), 32'd0);
        check_eq("rst_bitstring", 32'(bitstring), 32'd0);
        check_eq("rst_word_count", 32'(word_count), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("rst_sin_ready", 32'(sin_ready), 32'd1);

        // Single word 101
        bs_ready = 1'b1;
        send_bit(1'b1);
        send_bit(1'b0);
        check_eq("w1_not_yet", 32'(bs_valid), 32'd0);
        send_bit(1'b1);
        check_eq("w1_valid", 32'(bs_valid), 32'd1);
        check_eq("w1_bits", 32'(bitstring), 32'b101);
        sin_valid = 1'b0;
        tick();
        exp_wc++;
        check_eq("w1_drop", 32'(bs_valid), 32'd0);
        check_eq("w1_count", 32'(word_count), 32'(exp_wc));
        check_eq("w1_hold", 32'(bitstring), 32'b101);

        // Backpressure on word 110, then deliver + accept on the same edge
        bs_ready = 1'b0;
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        check_eq("bp_valid", 32'(bs_valid), 32'd1);
        check_eq("bp_sin_ready", 32'(sin_ready), 32'd0);
        send_bit(1'b0);
        send_bit(1'b0);
        check_eq("bp_stable", 32'(bitstring), 32'b110);
        check_eq("bp_still_valid", 32'(bs_valid), 32'd1);
        check_eq("bp_count", 32'(word_count), 32'(exp_wc));
        bs_ready = 1'b1;
        sin_bit  = 1'b1;
        #1;
        check_eq("bp_ready_follow", 32'(sin_ready), 32'd1);
        tick();
        exp_wc++;
        check_eq("bp_delivered", 32'(bs_valid), 32'd0);
        check_eq("bp_count2", 32'(word_count), 32'(exp_wc));
        send_bit(1'b0);
        send_bit(1'b1);
        check_eq("bp_next_valid", 32'(bs_valid), 32'd1);
        check_eq("bp_next_bits", 32'(bitstring), 32'b101);
        sin_valid = 1'b0;
        tick();
        exp_wc++;
        check_eq("bp_count3", 32'(word_count), 32'(exp_wc));

        // Streaming 111000011 with no stalls
        stream = 9'b111000011;
        for (int i = 0; i < 9; i++) begin
            check_eq("st_sin_ready", 32'(sin_ready), 32'd1);
            send_bit(stream[8 - i]);
            check_eq("st_valid", 32'(bs_valid), (i % 3 == 2) ? 32'd1 : 32'd0);
            if (i % 3 == 2) begin
                exp_word = (i == 2) ? 3'b111 : ((i == 5) ? 3'b000 : 3'b011);
                check_eq("st_word", 32'(bitstring), 32'(exp_word));
            end
        end
        sin_valid = 1'b0;
        tick();
        exp_wc += 3;
        check_eq("st_count", 32'(word_count), 32'(exp_wc));

        // Abort drops a partial word
        send_bit(1'b1);
        send_bit(1'b1);
        abort = 1'b1;
        send_bit(1'b1);
        abort = 1'b0;
        check_eq("ab_partial_clr", 32'(bs_valid), 32'd0);
        send_bit(1'b0);
        send_bit(1'b0);
        check_eq("ab_not_early", 32'(bs_valid), 32'd0);
        send_bit(1'b1);
        check_eq("ab_valid", 32'(bs_valid), 32'd1);
        check_eq("ab_bits", 32'(bitstring), 32'b001);
        sin_valid = 1'b0;
        tick();
        exp_wc++;
        check_eq("ab_count", 32'(word_count), 32'(exp_wc));

        // Abort while a word is pending, even with bs_ready high
        bs_ready = 1'b0;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        check_eq("abf_valid", 32'(bs_valid), 32'd1);
        sin_valid = 1'b0;
        bs_ready  = 1'b1;
        abort     = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("abf_dropped", 32'(bs_valid), 32'd0);
        check_eq("abf_count", 32'(word_count), 32'(exp_wc));
        check_eq("abf_bits_kept", 32'(bitstring), 32'b010);
        check_eq("abf_sin_ready", 32'(sin_ready), 32'd1);

        // Async reset with a pending word
        bs_ready = 1'b0;
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        check_eq("mr_pending", 32'(bs_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mr_bs_valid", 32'(bs_valid), 32'd0);
        check_eq("mr_bitstring", 32'(bitstring), 32'd0);
        check_eq("mr_count", 32'(word_count), 32'd0);
        exp_wc = 0;
        sin_valid = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        check_eq("mr_sin_ready", 32'(sin_ready), 32'd1);

        // Counter wrap after 256 deliveries
        bs_ready = 1'b1;
        for (int i = 0; i < 768; i++) send_bit(i[0]);
        check_eq("wr_pending", 32'(bs_valid), 32'd1);
        check_eq("wr_count255", 32'(word_count), 32'd255);
        sin_valid = 1'b0;
        tick();
        check_eq("wr_count0", 32'(word_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
